// File: rtl/servo_ramp.sv
// servo_ramp: slews an 8-bit PWM duty toward a handshaken target position,
// moving at most STEP counts per prescaled tick.
module servo_ramp #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int TICK_US     = 20000,
    parameter int STEP        = 4,
    parameter int DUTY_MIN    = 0,
    parameter int DUTY_MAX    = 255,
    parameter int RESET_DUTY  = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] target,
    input  logic       target_valid,
    output logic       target_ready,
    output logic [7:0] duty,
    output logic       busy,
    output logic       done
);
    // multiply before dividing so sub-MHz clocks still give a nonzero interval
    localparam longint TICK_L      = longint'(CLK_FREQ_HZ) * longint'(TICK_US) / 64'sd1000000;
    localparam int     TICK_CYCLES = int'(TICK_L);
    localparam int     CW          = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST  = CW'(TICK_CYCLES - 1);
    localparam logic [7:0]    MIN_D = 8'(DUTY_MIN);
    localparam logic [7:0]    MAX_D = 8'(DUTY_MAX);
    localparam logic [7:0]    RST_D = 8'(RESET_DUTY);
    localparam logic [7:0]    STEP8 = 8'(STEP);
    localparam logic [8:0]    STEP9 = 9'(STEP);

    logic [CW-1:0]     cnt;
    logic [7:0]        tgt_q;
    logic [7:0]        clamped;
    logic signed [8:0] diff;
    logic [8:0]        mag;
    logic              tick;
    logic              near;

    assign target_ready = 1'b1;
    assign busy         = duty != tgt_q;
    assign tick         = cnt == LAST;
    assign clamped      = target < MIN_D ? MIN_D : (target > MAX_D ? MAX_D : target);
    assign diff         = $signed({1'b0, tgt_q}) - $signed({1'b0, duty});
    assign mag          = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    assign near         = mag <= STEP9;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            duty  <= RST_D;
            tgt_q <= RST_D;
            done  <= 1'b0;
        end else begin
            cnt  <= tick ? '0 : cnt + CW'(1);
            done <= tick && busy && near;
            if (target_valid)
                tgt_q <= clamped;
            // step uses the pre-edge tgt_q; a same-edge transfer applies from the next tick
            if (tick && busy)
                duty <= near ? tgt_q : (diff[8] ? duty - STEP8 : duty + STEP8);
        end
    end
endmodule
